// File: rtl/id_ex_register_pkg.sv
// rtl/id_ex_register_pkg.sv - shared ALU, shift-direction and opcode encodings for the ID/EX stage
package id_ex_register_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [1:0] SHIFT_LEFT          = 2'b00;
   localparam logic [1:0] SHIFT_RIGHT_LOGICAL = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT_ARITH   = 2'b11;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // SLL and every non-shift op share the LEFT code
   function automatic logic [1:0] shift_dir_of(input alu_op_e op);
      case (op)
         ALU_SRL: shift_dir_of = SHIFT_RIGHT_LOGICAL;
         ALU_SRA: shift_dir_of = SHIFT_RIGHT_ARITH;
         default: shift_dir_of = SHIFT_LEFT;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_register_decode.sv
// rtl/id_ex_register_decode.sv - combinational execute-control decode feeding the ID/EX register
module ex_decode
   import id_ex_register_pkg::*;
(
   input  logic        valid,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic [4:0]  rd,
   input  logic [63:0] rs2_data,
   input  logic [63:0] imm,
   output logic [63:0] op_b,
   output logic [3:0]  alu_op,
   output logic [1:0]  shift_dir,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        illegal
);

   alu_op_e op;
   logic    is_op;

   always_comb begin
      op        = ALU_ADD;
      op_b      = imm;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      is_op     = (opcode == OPC_OP);
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            op_b      = is_op ? rs2_data : imm;
            reg_write = (rd != 5'd0);
            // funct7[5] picks SUB only for register ops; for OP-IMM it is immediate bits
            case (funct3)
               3'b000:  op = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  op = ALU_SLL;
               3'b010:  op = ALU_SLT;
               3'b011:  op = ALU_SLTU;
               3'b100:  op = ALU_XOR;
               3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         OPC_LOAD: begin
            mem_read  = 1'b1;
            reg_write = (rd != 5'd0);
         end
         OPC_STORE: mem_write = 1'b1;
         OPC_BRANCH: begin
            op     = ALU_SUB;
            op_b   = rs2_data;
            branch = 1'b1;
         end
         default: illegal = valid;
      endcase
      alu_op    = op;
      shift_dir = shift_dir_of(op);
   end

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with stall, flush bubble and illegal-opcode flag
module id_ex_register
   import id_ex_register_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        valid_in,
   input  logic [63:0] pc_in,
   input  logic [63:0] rs1_data_in,
   input  logic [63:0] rs2_data_in,
   input  logic [63:0] imm_in,
   input  logic [4:0]  rd_in,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [6:0]  funct7_in,
   output logic        valid_out,
   output logic [63:0] pc_out,
   output logic [63:0] op_a_out,
   output logic [63:0] op_b_out,
   output logic [63:0] store_data_out,
   output logic [4:0]  rd_out,
   output logic [3:0]  alu_op_out,
   output logic [1:0]  shift_dir_out,
   output logic        reg_write_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic        branch_out,
   output logic        illegal_out
);

   logic [63:0] dec_op_b;
   logic [3:0]  dec_alu_op;
   logic [1:0]  dec_shift_dir;
   logic        dec_reg_write;
   logic        dec_mem_read;
   logic        dec_mem_write;
   logic        dec_branch;
   logic        dec_illegal;
   logic        unused_funct7;

   assign unused_funct7 = ^{funct7_in[6], funct7_in[4:0]};

   ex_decode u_decode (
      .valid     (valid_in),
      .opcode    (opcode_in),
      .funct3    (funct3_in),
      .funct7_5  (funct7_in[5]),
      .rd        (rd_in),
      .rs2_data  (rs2_data_in),
      .imm       (imm_in),
      .op_b      (dec_op_b),
      .alu_op    (dec_alu_op),
      .shift_dir (dec_shift_dir),
      .reg_write (dec_reg_write),
      .mem_read  (dec_mem_read),
      .mem_write (dec_mem_write),
      .branch    (dec_branch),
      .illegal   (dec_illegal)
   );

   // Bubbles clear only valid and control; data registers keep their contents
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out      <= 1'b0;
         pc_out         <= '0;
         op_a_out       <= '0;
         op_b_out       <= '0;
         store_data_out <= '0;
         rd_out         <= '0;
         alu_op_out     <= ALU_ADD;
         shift_dir_out  <= SHIFT_LEFT;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         branch_out     <= 1'b0;
         illegal_out    <= 1'b0;
      end else if (flush || (!stall && (!valid_in || dec_illegal))) begin
         valid_out      <= 1'b0;
         alu_op_out     <= ALU_ADD;
         shift_dir_out  <= SHIFT_LEFT;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         branch_out     <= 1'b0;
         illegal_out    <= !flush && dec_illegal;
      end else if (!stall) begin
         valid_out      <= 1'b1;
         pc_out         <= pc_in;
         op_a_out       <= rs1_data_in;
         op_b_out       <= dec_op_b;
         store_data_out <= rs2_data_in;
         rd_out         <= rd_in;
         alu_op_out     <= dec_alu_op;
         shift_dir_out  <= dec_shift_dir;
         reg_write_out  <= dec_reg_write;
         mem_read_out   <= dec_mem_read;
         mem_write_out  <= dec_mem_write;
         branch_out     <= dec_branch;
         illegal_out    <= 1'b0;
      end
   end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 The block SHALL have these control inputs: stall input 1 hold stage; flush input 1 insert bubble.
REQ-003 The block SHALL have these decode-side inputs: valid_in input 1 decode slot holds an instruction; pc_in input 64 instruction PC; rs1_data_in input 64 and rs2_data_in input 64 register operands; imm_in input 64 sign-extended immediate.
REQ-004 The block SHALL have these field inputs: rd_in input 5 destination register; opcode_in input 7; funct3_in input 3; funct7_in input 7.
REQ-005 The block SHALL have these outputs: valid_out output 1; pc_out output 64; op_a_out output 64; op_b_out output 64; store_data_out output 64; rd_out output 5.
REQ-006 The block SHALL have these control outputs: alu_op_out output 4; shift_dir_out output 2 (shifter direction code); reg_write_out output 1; mem_read_out output 1; mem_write_out output 1; branch_out output 1; illegal_out output 1.

Function
REQ-007 The block SHALL register all outputs on the rising edge of clk, with one-cycle latency from inputs to outputs.
REQ-008 The block SHALL treat a flush as a bubble: when flush=1, valid_out and all control outputs SHALL be 0 next cycle, regardless of stall.
REQ-009 The block SHALL hold every output register unchanged when stall=1 and flush=0.
REQ-010 The block SHALL load a bubble when stall=0, flush=0 and valid_in=0: valid_out, control outputs and illegal_out 0; data outputs don't-care.
REQ-011 The block SHALL load the decoded instruction when stall=0, flush=0 and valid_in=1: valid_out=1, pc_out=pc_in, op_a_out=rs1_data_in, store_data_out=rs2_data_in, rd_out=rd_in.
REQ-012 The block SHALL select op_b_out: imm_in for opcodes 0010011 (OP-IMM), 0000011 (LOAD) and 0100011 (STORE); rs2_data_in for 0110011 (OP) and 1100011 (BRANCH).
REQ-013 The block SHALL decode alu_op_out for OP and OP-IMM by funct3: 000 ADD, or SUB only when OP and funct7_in[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7_in[5]=1 else SRL; 110 OR; 111 AND.
REQ-014 The block SHALL decode alu_op_out as ADD for LOAD and STORE, and as SUB for BRANCH.
REQ-015 The block SHALL decode shift_dir_out as: 2'b00 for SLL, 2'b01 for SRL, 2'b11 for SRA, and 2'b00 for all non-shift operations.
REQ-016 The block SHALL pass the shift amount unmasked in op_b_out; the shifter uses bits [4:0] only.
REQ-017 The block SHALL set the control flags as follows: reg_write_out=1 for OP, OP-IMM and LOAD with rd_in≠0; mem_read_out=1 for LOAD; mem_write_out=1 for STORE; branch_out=1 for BRANCH.
REQ-018 The block SHALL treat any other opcode with valid_in=1 as illegal: load a bubble with illegal_out=1 for exactly one cycle, or until the next non-stalled load.
REQ-019 The block SHALL give reset priority over flush, and flush priority over stall.

Reset
REQ-020 The block SHALL, when reset=1 at a clk edge, clear all outputs to 0 (valid_out=0, alu_op_out=ADD, shift_dir_out=2'b00).
REQ-021 The block SHALL discard an instruction held by stall when reset is asserted mid-stall, with no output change after reset deasserts until the next load.

Structure
REQ-022 A shared package SHALL hold the alu_op encodings (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9), the shift direction constants (LEFT 2'b00, RIGHT_LOGICAL 2'b01, RIGHT_ARITH 2'b11) and the opcode constants.
REQ-023 Decode logic SHALL be a combinational sub-module, ex_decode, feeding the pipeline register.

Verification
REQ-024 The bench SHALL cover OP-IMM SRAI: opcode 0010011, funct3 101, funct7 0100000, imm 5 -> next cycle alu_op=SRA, shift_dir=2'b11, op_b=5, reg_write=1.
REQ-025 The bench SHALL cover R-type SUB: funct7 0100000, funct3 000, rs1=10, rs2=3 -> alu_op=SUB, op_a=10, op_b=3; ADDI with funct7[5]=1 -> ADD.
REQ-026 The bench SHALL cover stall held 3 cycles with changing inputs -> outputs constant; and flush+stall together -> valid_out=0 next cycle.
REQ-027 The bench SHALL cover illegal opcode 1111111 with valid_in=1 -> valid_out=0, illegal_out=1 for one cycle, then 0.
REQ-028 The bench SHALL cover reset asserted during stall with a valid STORE held -> all outputs 0; after release with valid_in=0 -> outputs stay 0.
REQ-029 The bench SHALL cover LOAD with rd_in=0 -> mem_read=1, reg_write=0, op_b=imm_in.
